// File: rtl/grant_controller_pkg.sv
// Shared arbiter definitions: FSM encoding, default sizes and the index-to-one-hot helper.
package grant_controller_pkg;

    localparam int unsigned DEFAULT_NUM_PERIPH = 16;
    localparam int unsigned DEFAULT_IDX_WIDTH  = 4;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GRANT = 2'b01;
    localparam logic [1:0] ST_GAP   = 2'b10;

    // Index 0 maps to bit 0 of the returned vector (line 1 of a [N:1] bus).
    function automatic logic [DEFAULT_NUM_PERIPH-1:0] idx_to_onehot(
        input logic [DEFAULT_IDX_WIDTH-1:0] idx
    );
        logic [DEFAULT_NUM_PERIPH-1:0] one;
        one = {{(DEFAULT_NUM_PERIPH-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/grant_controller_hold_timer.sv
// Saturating cycle counter with clear and enable; terminal flags count == LIMIT-1.
module grant_controller_hold_timer #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q < WIDTH'(LIMIT))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/grant_controller.sv
// Accepts an arbiter winner, holds a registered one-hot grant until release or
// timeout, then enforces a guard gap before the next owner.
module grant_controller
    import grant_controller_pkg::*;
#(
    parameter int unsigned NUM_PERIPH = DEFAULT_NUM_PERIPH,
    parameter int unsigned IDX_WIDTH  = DEFAULT_IDX_WIDTH,
    parameter int unsigned MAX_HOLD   = 64,
    parameter int unsigned CNT_WIDTH  = 7,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winner_valid_i,
    input  logic [IDX_WIDTH-1:0]  winner_idx_i,
    output logic                  winner_ready_o,
    input  logic [NUM_PERIPH:1]   peripheral_controllers,
    output logic [NUM_PERIPH:1]   grant_o,
    output logic [IDX_WIDTH-1:0]  grant_idx_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic                  stale_o
);

    logic [1:0]            state_q, state_d;
    logic [NUM_PERIPH:1]   grant_q, grant_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  timeout_q, timeout_d;
    logic                  stale_q, stale_d;

    logic [NUM_PERIPH-1:0] one;
    logic [NUM_PERIPH-1:0] winner_sel;
    logic [NUM_PERIPH-1:0] owner_sel;
    logic                  winner_req;
    logic                  owner_req;
    logic                  transfer;
    logic                  hold_term;
    logic                  gap_term;

    // Out-of-range indices shift the bit off the top, so they read as "no request".
    assign one        = {{(NUM_PERIPH-1){1'b0}}, 1'b1};
    assign winner_sel = one << winner_idx_i;
    assign owner_sel  = one << idx_q;
    assign winner_req = |(winner_sel & peripheral_controllers);
    assign owner_req  = |(owner_sel & peripheral_controllers);

    assign winner_ready_o = (state_q == ST_IDLE) && !rst;
    assign transfer       = winner_valid_i && winner_ready_o;

    grant_controller_hold_timer #(
        .WIDTH (CNT_WIDTH),
        .LIMIT (MAX_HOLD)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q != ST_GRANT),
        .enable   (state_q == ST_GRANT),
        .terminal (hold_term)
    );

    grant_controller_hold_timer #(
        .WIDTH (CNT_WIDTH),
        .LIMIT (GAP_CYCLES)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q != ST_GAP),
        .enable   (state_q == ST_GAP),
        .terminal (gap_term)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        timeout_d = 1'b0;
        stale_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    if (winner_req) begin
                        idx_d   = winner_idx_i;
                        grant_d = winner_sel;
                        state_d = ST_GRANT;
                    end else begin
                        stale_d = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                // A request drop wins over a coincident timeout.
                if (!owner_req) begin
                    grant_d = '0;
                    state_d = ST_GAP;
                end else if (hold_term) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_term) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            timeout_q <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            timeout_q <= timeout_d;
            stale_q   <= stale_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign timeout_o   = timeout_q;
    assign stale_o     = stale_q;

endmodule

// File: tb/tb_grant_controller.sv
// Randomized and directed bench for grant_controller against an ownership-level model.
module tb_grant_controller;

    localparam int N        = 16;
    localparam int MAX_HOLD = 64;
    localparam int GAP      = 1;

    logic         clk;
    logic         rst;
    logic         winner_valid;
    logic [3:0]   winner_idx;
    logic         winner_ready;
    logic [N:1]   req;
    logic [N:1]   grant;
    logic [3:0]   grant_idx;
    logic         busy;
    logic         timeout;
    logic         stale;

    int checks;
    int errors;

    // Model: who owns the resource, how long they have held it, gap cycles left.
    int m_owner;
    int m_last;
    int m_held;
    int m_gap;
    bit m_timeout;
    bit m_stale;
    bit m_accepted;

    grant_controller dut (
        .clk                    (clk),
        .rst                    (rst),
        .winner_valid_i         (winner_valid),
        .winner_idx_i           (winner_idx),
        .winner_ready_o         (winner_ready),
        .peripheral_controllers (req),
        .grant_o                (grant),
        .grant_idx_o            (grant_idx),
        .busy_o                 (busy),
        .timeout_o              (timeout),
        .stale_o                (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_last    = 0;
        m_held    = 0;
        m_gap     = 0;
        m_timeout = 1'b0;
        m_stale   = 1'b0;
    endtask

    task automatic model_edge();
        m_timeout  = 1'b0;
        m_stale    = 1'b0;
        m_accepted = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            if (!req[m_owner + 1]) begin
                m_owner = -1;
                m_gap   = GAP;
            end else if (m_held == MAX_HOLD) begin
                m_owner   = -1;
                m_gap     = GAP;
                m_timeout = 1'b1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (winner_valid) begin
            m_accepted = 1'b1;
            if (int'(winner_idx) < N && req[int'(winner_idx) + 1]) begin
                m_owner = int'(winner_idx);
                m_last  = m_owner;
                m_held  = 0;
            end else begin
                m_stale = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        logic [N:1] exp_grant;
        bit         exp_busy;
        exp_grant = '0;
        if (m_owner >= 0) exp_grant[m_owner + 1] = 1'b1;
        exp_busy = (m_owner >= 0) || (m_gap > 0);
        check_eq("grant", 32'(grant), 32'(exp_grant));
        check_eq("busy", 32'(busy), 32'(exp_busy));
        check_eq("ready", 32'(winner_ready), 32'(!exp_busy && !rst));
        check_eq("timeout", 32'(timeout), 32'(m_timeout));
        check_eq("stale", 32'(stale), 32'(m_stale));
        if (exp_busy) check_eq("grant_idx", 32'(grant_idx), 32'(m_last));
        check_eq("no_overlap_3_8", 32'(grant[3] & grant[8]), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic offer(input int idx);
        winner_valid = 1'b1;
        winner_idx   = 4'(idx);
        step();
        winner_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        winner_valid = 1'b0;
        winner_idx   = '0;
        req          = '0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("ready_after_reset", 32'(winner_ready), 32'd1);

        // Basic grant to index 3 (line 4), released by request drop.
        req[4] = 1'b1;
        offer(3);
        check_eq("basic_grant", 32'(grant), 32'h0008);
        run(5);
        req[4] = 1'b0;
        step();
        check_eq("basic_release", 32'(grant), 32'h0000);
        run(2);

        // Timeout: line 1 held high forever, grant must last exactly MAX_HOLD cycles.
        begin
            int high_cycles;
            high_cycles = 0;
            req[1] = 1'b1;
            offer(0);
            while (grant == 16'h0001 && high_cycles < 200) begin
                high_cycles++;
                step();
            end
            check_eq("timeout_hold_len", 32'(high_cycles), 32'(MAX_HOLD));
            check_eq("timeout_pulse", 32'(timeout), 32'd1);
            step();
            check_eq("timeout_one_cycle", 32'(timeout), 32'd0);
            req[1] = 1'b0;
            run(2);
        end

        // Stale winner: index 9 with line 10 low.
        offer(9);
        check_eq("stale_pulse", 32'(stale), 32'd1);
        check_eq("stale_ready", 32'(winner_ready), 32'd1);
        step();

        // Back-pressure: idx 7 offered while idx 2 owns; must wait for the gap.
        begin
            int waited;
            waited = 0;
            req[3] = 1'b1;
            req[8] = 1'b1;
            offer(2);
            winner_valid = 1'b1;
            winner_idx   = 4'd7;
            run(4);
            req[3] = 1'b0;
            step();
            while (!m_accepted && waited < 20) begin
                waited++;
                step();
            end
            check_eq("bp_accepted", 32'(m_accepted), 32'd1);
            winner_valid = 1'b0;
            check_eq("bp_grant", 32'(grant), 32'h0080);
            req[8] = 1'b0;
            run(3);
        end

        // Asynchronous reset while line 16 owns the resource.
        req[16] = 1'b1;
        offer(15);
        run(3);
        check_eq("pre_reset_grant", 32'(grant), 32'h8000);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        #2;
        rst = 1'b0;
        req[16] = 1'b0;
        req[6]  = 1'b1;
        offer(5);
        check_eq("post_reset_grant", 32'(grant), 32'h0020);
        req[6] = 1'b0;
        run(3);

        // Coincident: request drops on the edge where the timeout would fire.
        req[1] = 1'b1;
        offer(0);
        run(MAX_HOLD - 1);
        req[1] = 1'b0;
        step();
        check_eq("coincident_grant", 32'(grant), 32'h0000);
        check_eq("coincident_no_timeout", 32'(timeout), 32'd0);
        run(2);

        // Random traffic: sticky request lines, random valid and index.
        for (int c = 0; c < 600; c++) begin
            for (int l = 1; l <= N; l++) begin
                if ($urandom_range(0, 9) == 0) req[l] = ~req[l];
            end
            winner_valid = 1'($urandom_range(0, 1));
            winner_idx   = 4'($urandom_range(0, N - 1));
            step();
        end
        winner_valid = 1'b0;
        run(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
